// File: rtl/pman_pkg.sv
// Shared constants for the pac-man board: button bit positions, debounce time, tile codes.
package pman_pkg;

  localparam int BTN_UP    = 0;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_MID   = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_DOWN  = 4;
  localparam int NBTN      = 5;

  // 10 ms at the 148.5 MHz pixel clock
  localparam int DEBOUNCE_10MS = 1485000;

  typedef enum logic [1:0] {
    TILE_BG   = 2'd0,
    TILE_WALL = 2'd1,
    TILE_COIN = 2'd2
  } tile_t;

endpackage

// File: rtl/btn_conditioner_debounce.sv
// One button: 2-FF synchroniser, mismatch counter, debounced level and press strobe.
module btn_debounce
  import pman_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEBOUNCE_10MS,
  parameter int CNT_W        = 21
) (
  input  logic clk_pix,
  input  logic rstn,
  input  logic raw,
  output logic level,
  output logic press
);

  logic             sync_q1;
  logic             sync_q2;
  logic             stable;
  logic [CNT_W-1:0] cnt;
  logic             cnt_done;

  assign cnt_done = (cnt == CNT_W'(DEBOUNCE_CYC - 1));

  always_ff @(posedge clk_pix or negedge rstn) begin
    if (!rstn) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      stable  <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
      if (sync_q2 == stable) begin
        cnt <= '0;
      end else if (cnt_done) begin
        stable <= sync_q2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // High in the cycle whose closing edge flips stable 0->1, so pend sets on that same edge
  assign press = sync_q2 & ~stable & cnt_done;
  assign level = stable;

endmodule

// File: rtl/btn_conditioner.sv
// Debounces the board buttons and holds each press until the next frame_tick consumes it.
module btn_conditioner #(
  parameter int NBTN         = pman_pkg::NBTN,
  parameter int DEBOUNCE_CYC = pman_pkg::DEBOUNCE_10MS,
  parameter int CNT_W        = 21,
  parameter int REPEAT       = 1
) (
  input  logic            clk_pix,
  input  logic            rstn,
  input  logic [NBTN-1:0] btn_raw,
  input  logic            frame_tick,
  output logic [NBTN-1:0] btn_pulse,
  output logic [NBTN-1:0] btn_level
);

  logic [NBTN-1:0] stable;
  logic [NBTN-1:0] press;
  logic [NBTN-1:0] pend;

  for (genvar i = 0; i < NBTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .CNT_W        (CNT_W)
    ) u_debounce (
      .clk_pix (clk_pix),
      .rstn    (rstn),
      .raw     (btn_raw[i]),
      .level   (stable[i]),
      .press   (press[i])
    );
  end

  // A press on the tick cycle wins, so the tick sees the old pend and the press waits a frame
  always_ff @(posedge clk_pix or negedge rstn) begin
    if (!rstn) begin
      pend <= '0;
    end else begin
      pend <= press | (frame_tick ? '0 : pend);
    end
  end

  if (REPEAT != 0) begin : g_repeat
    assign btn_pulse = pend | stable;
  end else begin : g_single
    assign btn_pulse = pend;
  end

  assign btn_level = stable;

endmodule
